seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 4-digit seven-segment display. It walks an active-low one-cold digit select across four digits at a programmable refresh rate. It presents the matching 4-bit nibble of a double-buffered 16-bit display value, and inserts a blanking gap between digits to prevent ghosting. It feeds the segment decoder and the anode pins, and takes new display values from upstream logic through a valid/ready handshake.

---
 rtl/seg_scan_if.sv | 11 +
 rtl/seg_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// seg_scan_if: load handshake between upstream logic and the scan controller.
// Upstream (master) offers a 16-bit display value. The controller (slave)
// takes it when load_valid & load_ready.
interface seg_scan_if;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;

  modport master (output load_valid, load_data, input load_ready);
  modport slave  (input load_valid, load_data, output load_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit seven-segment scan controller.
// - Walks an active-low one-cold anode select across four digits.
// - Each slot opens with a blanking gap; hex_num is set up during that gap,
//   before the anode turns on.
// - New values land in a pending buffer. They are promoted to the active
//   buffer only while idle or at a frame boundary, so a frame never mixes two
//   values.
// Optional build macro SEG_SCAN_DIM_EN adds a brightness input that gates the
// anode inside the drive window.
module seg_scan_ctrl #(
  parameter int DIV_W     = 17,
  parameter int DIV_MAX   = 99999,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
`ifdef SEG_SCAN_DIM_EN
  input  logic [3:0]  brightness,
`endif
  seg_scan_if.slave   load_if,
  output logic [3:0]  digit_sel,
  output logic [3:0]  hex_num,
  output logic        blank,
  output logic        frame_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  localparam logic [DIV_W-1:0] CNT_LAST   = DIV_W'(DIV_MAX);
  localparam logic [DIV_W-1:0] BLANK_LAST = DIV_W'(BLANK_CYC - 1);

  logic [1:0]       state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n;
  logic [1:0]       idx, idx_n;
  logic [15:0]      active, active_n;
  logic [15:0]      pend, pend_n;
  logic             full, full_n;
  logic             fd_n, xfer, accept, anode_on;
  logic [3:0]       dsel_n, hex_n;
`ifdef SEG_SCAN_DIM_EN
  logic [DIV_W+3:0] cnt_pad;
`endif

  // Next-state: slot/digit sequencing, buffer promotion and load acceptance.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    active_n = active;
    pend_n   = pend;
    full_n   = full;
    fd_n     = 1'b0;
    xfer     = 1'b0;
    accept   = load_if.load_valid & load_if.load_ready;
    case (state)
      S_IDLE: begin
        xfer = full;
        if (en) state_n = S_BLANK;
      end
      S_BLANK, S_DRIVE: begin
        if (!en) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          idx_n   = 2'd0;
        end else if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          idx_n   = idx + 2'd1;
          state_n = S_BLANK;
          if (idx == 2'd3) begin
            fd_n = 1'b1;
            xfer = full;
          end
        end else begin
          cnt_n = cnt + DIV_W'(1);
          if (cnt == BLANK_LAST) state_n = S_DRIVE;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        idx_n   = 2'd0;
      end
    endcase
    // accept implies pending was empty, so it never collides with xfer
    if (xfer) begin
      active_n = pend;
      full_n   = 1'b0;
    end
    if (accept) begin
      pend_n = load_if.load_data;
      full_n = 1'b1;
    end
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    anode_on = (state_n == S_DRIVE);
`ifdef SEG_SCAN_DIM_EN
    cnt_pad  = {4'b0000, cnt_n};
    anode_on = anode_on & ((brightness == 4'hF) | (cnt_pad[3:0] < brightness));
`endif
    dsel_n = anode_on ? ~(4'b0001 << idx_n) : 4'hF;
    hex_n  = active_n[{idx_n, 2'b00} +: 4];
  end

  // State and output registers; async reset also drops the pending value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      cnt                <= '0;
      idx                <= 2'd0;
      active             <= '0;
      pend               <= '0;
      full               <= 1'b0;
      digit_sel          <= 4'hF;
      hex_num            <= 4'h0;
      blank              <= 1'b1;
      frame_done         <= 1'b0;
      load_if.load_ready <= 1'b1;
    end else begin
      state              <= state_n;
      cnt                <= cnt_n;
      idx                <= idx_n;
      active             <= active_n;
      pend               <= pend_n;
      full               <= full_n;
      digit_sel          <= dsel_n;
      hex_num            <= hex_n;
      blank              <= (dsel_n == 4'hF);
      frame_done         <= fd_n;
      load_if.load_ready <= ~full_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl (DIV_MAX=9, BLANK_CYC=2).
// A frame-position model pushes the expected outputs on each clock edge, and
// the checker pops and compares them on the falling edge. Directed checks
// cover the reset state, the handshake and the en/boundary corner cases.
module tb_seg_scan_ctrl;
  localparam int DIV_W = 4, DIV_MAX = 9, BLANK_CYC = 2;
  localparam int SLOT = DIV_MAX + 1, FRAME = 4 * SLOT;

  logic clk = 1'b0, rst_n = 1'b1, en = 1'b0;
  logic [3:0] digit_sel, hex_num;
  logic blank, frame_done;
`ifdef SEG_SCAN_DIM_EN
  logic [3:0] brightness = 4'hF;
`endif

  seg_scan_if ifc ();

  seg_scan_ctrl #(.DIV_W(DIV_W), .DIV_MAX(DIV_MAX), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
`ifdef SEG_SCAN_DIM_EN
    .brightness(brightness),
`endif
    .load_if(ifc.slave),
    .digit_sel(digit_sel), .hex_num(hex_num), .blank(blank), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] dsel;
    logic [3:0] hex;
    logic       blank;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0, n_pass = 0, n_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
  endtask

  // reference model: position within a 40-cycle frame while scanning
  logic        m_on = 1'b0, m_full = 1'b0;
  int          m_pos = 0;
  logic [15:0] m_act = '0, m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_on = 1'b0; m_pos = 0; m_act = '0; m_pend = '0; m_full = 1'b0;
      sb.delete();
    end else begin
      automatic logic acc = ifc.load_valid && !m_full;
      automatic logic fd = 1'b0;
      automatic logic on;
      automatic int   c, d;
      automatic exp_t e;
      if (!m_on) begin
        if (m_full) begin m_act = m_pend; m_full = 1'b0; end
        if (en) begin m_on = 1'b1; m_pos = 0; end
      end else if (!en) begin
        m_on = 1'b0; m_pos = 0;
      end else if (m_pos == FRAME - 1) begin
        fd = 1'b1; m_pos = 0;
        if (m_full) begin m_act = m_pend; m_full = 1'b0; end
      end else begin
        m_pos++;
      end
      if (acc) begin m_pend = ifc.load_data; m_full = 1'b1; end
      c  = m_pos % SLOT;
      d  = m_pos / SLOT;
      on = m_on && (c >= BLANK_CYC);
`ifdef SEG_SCAN_DIM_EN
      on = on && ((brightness == 4'hF) || (c < int'(brightness)));
`endif
      e.dsel  = on ? (d == 0 ? 4'b1110 : d == 1 ? 4'b1101 : d == 2 ? 4'b1011 : 4'b0111) : 4'b1111;
      e.hex   = m_act[d*4 +: 4];
      e.blank = !on;
      e.fd    = fd;
      e.rdy   = !m_full;
      sb.push_back(e);
    end
  end

  // checker: compare DUT outputs against the model on the falling edge
  always @(negedge clk) begin
    if (rst_n && sb.size() > 0) begin
      automatic exp_t e = sb.pop_front();
      chk("sb_dsel",  digit_sel,      e.dsel);
      chk("sb_hex",   hex_num,        e.hex);
      chk("sb_blank", blank,          e.blank);
      chk("sb_fd",    frame_done,     e.fd);
      chk("sb_rdy",   ifc.load_ready, e.rdy);
    end
  end

  always @(posedge clk) begin
    n_cyc++;
    if (n_cyc > 20000) begin
      $display("FAIL watchdog cycles=%0d limit=20000", n_cyc);
      $fatal(1, "watchdog");
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pos(input int p, input string tag);
    for (int i = 0; i < 3 * FRAME && !(m_on && m_pos == p); i++) cyc(1);
    chk(tag, m_pos, p);
  endtask

  initial begin
    int fd_cnt, fd_first, fd_last, n;
    ifc.load_valid = 1'b0;
    ifc.load_data  = '0;

    // reset state, asserted asynchronously before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dsel",  digit_sel,      4'hF);
    chk("rst_hex",   hex_num,        4'h0);
    chk("rst_blank", blank,          1'b1);
    chk("rst_fd",    frame_done,     1'b0);
    chk("rst_rdy",   ifc.load_ready, 1'b1);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // load while idle: promoted to active within two cycles
    ifc.load_valid = 1'b1; ifc.load_data = 16'h1234;
    cyc(1);
    ifc.load_valid = 1'b0;
    chk("idle_rdy_drop", ifc.load_ready, 1'b0);
    cyc(1);
    chk("idle_rdy_back", ifc.load_ready, 1'b1);
    chk("idle_hex",      hex_num,        4'h4);

    // scanning: frame_done every 40 cycles
    en = 1'b1;
    fd_cnt = 0; fd_first = 0; fd_last = 0;
    for (int k = 1; k <= 120; k++) begin
      cyc(1);
      if (frame_done) begin
        fd_cnt++;
        if (fd_cnt == 1) fd_first = k;
        fd_last = k;
      end
    end
    chk("fd_count", fd_cnt, 2);
    chk("fd_gap",   fd_last - fd_first, FRAME);

    // load mid-frame at digit 1, second load held while not ready
    wait_pos(12, "t3_align");
    ifc.load_valid = 1'b1; ifc.load_data = 16'hABCD;
    cyc(1);
    chk("t3_rdy_drop", ifc.load_ready, 1'b0);
    ifc.load_data = 16'h5555;
    n = 0;
    while (!ifc.load_ready && n < 2 * FRAME) begin cyc(1); n++; end
    chk("t3_rdy_back", ifc.load_ready, 1'b1);
    chk("t3_fd",       frame_done,     1'b1);
    chk("t3_hex_D",    hex_num,        4'hD);
    cyc(1);
    ifc.load_valid = 1'b0;
    chk("t3_5555_acc", ifc.load_ready, 1'b0);

    // load accepted exactly on a boundary edge: no bypass
    for (int i = 0; i < 3 * FRAME && !(m_pos == FRAME - 1 && !m_full); i++) cyc(1);
    chk("t4_align", m_pos, FRAME - 1);
    ifc.load_valid = 1'b1; ifc.load_data = 16'h9876;
    cyc(1);
    ifc.load_valid = 1'b0;
    chk("t4_fd",      frame_done,     1'b1);
    chk("t4_old_hex", hex_num,        4'h5);
    chk("t4_rdy",     ifc.load_ready, 1'b0);
    cyc(FRAME);
    chk("t4_fd2",     frame_done,     1'b1);
    chk("t4_new_hex", hex_num,        4'h6);

    // en dropped during digit 2 drive, then restart at digit 0
    wait_pos(25, "t5_align");
    en = 1'b0;
    cyc(1);
    chk("t5_off_dsel", digit_sel,  4'hF);
    chk("t5_off_fd",   frame_done, 1'b0);
    cyc(3);
    en = 1'b1;
    cyc(1);
    chk("t5_blank0", digit_sel, 4'hF);
    cyc(1);
    chk("t5_blank1", digit_sel, 4'hF);
    cyc(1);
    chk("t5_first",  digit_sel, 4'b1110);
    chk("t5_hex",    hex_num,   4'h6);

`ifdef SEG_SCAN_DIM_EN
    // dimming: partial, full and zero brightness
    brightness = 4'h4;
    cyc(FRAME);
    brightness = 4'hF;
    cyc(FRAME);
    brightness = 4'h0;
    fd_cnt = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      cyc(1);
      if (frame_done) fd_cnt++;
    end
    chk("dim0_fd", fd_cnt, 2);
    brightness = 4'hF;
`endif

    // reset asserted mid-drive: outputs clear without a clock edge
    wait_pos(5, "rst_align");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dsel",  digit_sel,      4'hF);
    chk("arst_blank", blank,          1'b1);
    chk("arst_hex",   hex_num,        4'h0);
    chk("arst_rdy",   ifc.load_ready, 1'b1);
    chk("arst_fd",    frame_done,     1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
